// File: rtl/fp_pkg.sv
// Shared definitions for the FP normalizer datapath.
//   norm_state_t : sequencer states of fp_norm_seq
//   EXP_W        : exponent width (signed two's complement)
//   EXP_MAX      : largest representable exponent (+127)
//   EXP_MIN      : smallest representable exponent (-128)
package fp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        ADJ  = 2'd2,
        DONE = 2'd3
    } norm_state_t;

    localparam int EXP_W = 8;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'h7F;  // +127
    localparam logic [EXP_W-1:0] EXP_MIN = 8'h80;  // -128

endpackage

// File: rtl/fp_norm_seq_exp_adder.sv
// Combinational saturating exponent adder.
//   a, b : signed EXP_W-bit operands
//   sum  : a + b, clamped to [EXP_MIN, EXP_MAX]
module FPExpAdder
    import fp_pkg::*;
(
    input  logic [EXP_W-1:0] a,
    input  logic [EXP_W-1:0] b,
    output logic [EXP_W-1:0] sum
);

    logic [EXP_W:0] wide;

    // Sign-extend by one bit so the true sum always fits.
    assign wide = {a[EXP_W-1], a} + {b[EXP_W-1], b};

    // The top two bits disagree only when the 8-bit result wrapped:
    // 01 means positive overflow, 10 means negative overflow.
    always_comb begin
        sum = wide[EXP_W-1:0];
        if (wide[EXP_W:EXP_W-1] == 2'b01) begin
            sum = EXP_MAX;
        end else if (wide[EXP_W:EXP_W-1] == 2'b10) begin
            sum = EXP_MIN;
        end
    end

endmodule

// File: rtl/fp_norm_seq.sv
// Multi-cycle mantissa normalizer with saturating exponent adjust.
// Shifts the mantissa left one bit per cycle until its MSB is set, counting
// the shifts, then applies the exponent change through one FPExpAdder.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; out_valid holds, with all outputs stable, until out_ready.
//
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (in_ready = state is IDLE)
//   in_exp               : signed 8-bit exponent
//   in_mant              : unnormalized mantissa, MANT_W bits
//   in_carry             : mantissa overflow bit, weight 2^MANT_W
//   out_valid / out_ready: result handshake (out_valid = state is DONE)
//   out_exp              : signed saturated result exponent
//   out_mant             : normalized mantissa
//   out_zero             : operand mantissa and carry were both zero
//   out_sat              : exponent was clamped
module fp_norm_seq
    import fp_pkg::*;
#(
    parameter int MANT_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    input  logic              in_carry,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EXP_W-1:0]  out_exp,
    output logic [MANT_W-1:0] out_mant,
    output logic              out_zero,
    output logic              out_sat
);

    localparam int CNT_W = $clog2(MANT_W);

    norm_state_t       state;
    logic [MANT_W-1:0] mant;
    logic [CNT_W-1:0]  cnt;
    logic [EXP_W-1:0]  exp_q;
    logic [EXP_W-1:0]  change;
    logic [EXP_W-1:0]  adj_exp;
    logic [EXP_W:0]    true_sum;
    logic              sat;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    FPExpAdder u_exp_add (
        .a   (exp_q),
        .b   (change),
        .sum (adj_exp)
    );

    // Saturation flag from the unclamped 9-bit sum.
    assign true_sum = {exp_q[EXP_W-1], exp_q} + {change[EXP_W-1], change};
    assign sat      = true_sum[EXP_W] ^ true_sum[EXP_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mant     <= '0;
            cnt      <= '0;
            exp_q    <= '0;
            change   <= '0;
            out_exp  <= '0;
            out_mant <= '0;
            out_zero <= 1'b0;
            out_sat  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        exp_q <= in_exp;
                        if (in_carry) begin
                            // Carry becomes the new MSB; the old LSB is dropped.
                            mant     <= {1'b1, in_mant[MANT_W-1:1]};
                            change   <= EXP_W'(1);
                            out_zero <= 1'b0;
                            state    <= ADJ;
                        end else if (in_mant == '0) begin
                            // Zero needs no normalization: result is final now.
                            out_mant <= '0;
                            out_exp  <= EXP_MIN;
                            out_zero <= 1'b1;
                            out_sat  <= 1'b0;
                            state    <= DONE;
                        end else begin
                            mant     <= in_mant;
                            cnt      <= '0;
                            out_zero <= 1'b0;
                            state    <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (mant[MANT_W-1]) begin
                        change <= EXP_W'(0) - EXP_W'(cnt);
                        state  <= ADJ;
                    end else begin
                        mant <= mant << 1;
                        cnt  <= cnt + CNT_W'(1);
                    end
                end
                ADJ: begin
                    out_exp  <= adj_exp;
                    out_mant <= mant;
                    out_sat  <= sat;
                    state    <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
